// File: rtl/home_pkg.sv
// Shared keypad / door-lock definitions: key codes, FSM state encoding and
// sizing helpers used by keypad_entry and its accumulator.
package home_pkg;

  localparam int unsigned PW_W_DEF = 17;
  localparam int unsigned CNT_W    = 3;

  localparam logic [3:0] KEY_CLEAR  = 4'hA;
  localparam logic [3:0] KEY_ENTER  = 4'hB;
  localparam logic [3:0] KEY_CHANGE = 4'hC;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ENTRY,
    ST_CHG_OLD,
    ST_CHG_NEW,
    ST_PRESENT,
    ST_WAIT_RESP,
    ST_LOCKED
  } kp_state_t;

  function automatic logic is_digit(input logic [3:0] code);
    return code <= 4'd9;
  endfunction

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/keypad_digit_acc.sv
// Decimal multiply-add accumulator: acc = acc*10 + digit, with a digit counter
// that saturates at MAX_DIGITS (extra digits are dropped).
module keypad_digit_acc
  import home_pkg::*;
#(
  parameter int unsigned MAX_DIGITS = 5,
  parameter int unsigned PW_W       = PW_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             load,
  input  logic [3:0]       digit,
  output logic [PW_W-1:0]  acc,
  output logic [CNT_W-1:0] count
);

  localparam logic [PW_W-1:0] TEN = PW_W'(10);

  logic [PW_W-1:0]  acc_q;
  logic [CNT_W-1:0] count_q;
  logic             room;

  assign room = count_q < CNT_W'(MAX_DIGITS);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q   <= '0;
      count_q <= '0;
    end else if (clear) begin
      acc_q   <= '0;
      count_q <= '0;
    end else if (load && room) begin
      acc_q   <= acc_q * TEN + PW_W'(digit);
      count_q <= count_q + 1'b1;
    end
  end

  assign acc   = acc_q;
  assign count = count_q;

endmodule

// File: rtl/keypad_entry.sv
// Keypad front-end for the smart_home door-lock path: builds password words,
// presents them with rs/e button levels. Failed-attempt lockout is enabled by
// defining KEYPAD_LOCKOUT_EN.
module keypad_entry
  import home_pkg::*;
#(
  parameter int unsigned MAX_DIGITS  = 5,
  parameter int unsigned PW_W        = PW_W_DEF,
  parameter int unsigned TIMEOUT_CYC = 1000,
  parameter int unsigned E_HOLD      = 4,
  parameter int unsigned RESP_WAIT   = 8,
  parameter int unsigned MAX_FAIL    = 3,
  parameter int unsigned LOCKOUT_CYC = 5000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            key_valid,
  input  logic [3:0]      key_code,
  input  logic            unlock,
  output logic [PW_W-1:0] in_password,
  output logic [PW_W-1:0] change_password,
  output logic            rs_button,
  output logic            e_button,
  output logic            busy,
  output logic            locked,
  output logic [2:0]      digit_count
);

  // One cycle timer is shared by every timed state; it clears on each state change.
  localparam int unsigned TMR_MAX = max2(max2(TIMEOUT_CYC, E_HOLD), max2(RESP_WAIT, LOCKOUT_CYC));
  localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);

  kp_state_t        state_q, state_d;
  logic [TMR_W-1:0] tmr_q;
  logic [PW_W-1:0]  acc;
  logic [CNT_W-1:0] digit_cnt;
  logic             acc_clear, acc_load, key_taken;
  logic             pw_load, cpw_load, rs_set, rs_clr;
  logic             fail_clr, fail_inc;
  logic             rs_q;

`ifdef KEYPAD_LOCKOUT_EN
  localparam int unsigned FAIL_W = $clog2(MAX_FAIL + 1);
  logic [FAIL_W-1:0] fail_cnt_q;
  logic              seen_q;
`else
  localparam int unsigned unused_max_fail = MAX_FAIL;
  logic unused_unlock;
  assign unused_unlock = unlock;
`endif

  keypad_digit_acc #(
    .MAX_DIGITS(MAX_DIGITS),
    .PW_W      (PW_W)
  ) u_acc (
    .clk  (clk),
    .rst  (rst),
    .clear(acc_clear),
    .load (acc_load),
    .digit(key_code),
    .acc  (acc),
    .count(digit_cnt)
  );

  always_comb begin
    state_d   = state_q;
    acc_clear = 1'b0;
    acc_load  = 1'b0;
    key_taken = 1'b0;
    pw_load   = 1'b0;
    cpw_load  = 1'b0;
    rs_set    = 1'b0;
    rs_clr    = 1'b0;
    fail_clr  = 1'b0;
    fail_inc  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (key_valid && is_digit(key_code)) begin
          acc_load  = 1'b1;
          key_taken = 1'b1;
          state_d   = ST_ENTRY;
        end else if (key_valid && key_code == KEY_CHANGE) begin
          key_taken = 1'b1;
          state_d   = ST_CHG_OLD;
        end
      end
      ST_ENTRY, ST_CHG_OLD, ST_CHG_NEW: begin
        // Accepted keys take priority over a same-cycle timeout.
        if (key_valid && is_digit(key_code)) begin
          acc_load  = 1'b1;
          key_taken = 1'b1;
        end else if (key_valid && key_code == KEY_CLEAR) begin
          acc_clear = 1'b1;
          key_taken = 1'b1;
          state_d   = ST_IDLE;
        end else if (key_valid && key_code == KEY_ENTER && digit_cnt != '0) begin
          key_taken = 1'b1;
          acc_clear = 1'b1;
          if (state_q == ST_ENTRY) begin
            pw_load = 1'b1;
            rs_clr  = 1'b1;
            state_d = ST_PRESENT;
          end else if (state_q == ST_CHG_OLD) begin
            pw_load = 1'b1;
            state_d = ST_CHG_NEW;
          end else begin
            cpw_load = 1'b1;
            rs_set   = 1'b1;
            state_d  = ST_PRESENT;
          end
        end else if (tmr_q == TMR_W'(TIMEOUT_CYC - 1)) begin
          acc_clear = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      ST_PRESENT: begin
        if (tmr_q == TMR_W'(E_HOLD - 1)) begin
          rs_clr = 1'b1;
`ifdef KEYPAD_LOCKOUT_EN
          state_d = rs_q ? ST_IDLE : ST_WAIT_RESP;
`else
          state_d = ST_IDLE;
`endif
        end
      end
`ifdef KEYPAD_LOCKOUT_EN
      ST_WAIT_RESP: begin
        if (tmr_q == TMR_W'(RESP_WAIT - 1)) begin
          if (seen_q || unlock) begin
            fail_clr = 1'b1;
            state_d  = ST_IDLE;
          end else begin
            fail_inc = 1'b1;
            state_d  = (fail_cnt_q >= FAIL_W'(MAX_FAIL - 1)) ? ST_LOCKED : ST_IDLE;
          end
        end
      end
      ST_LOCKED: begin
        if (tmr_q == TMR_W'(LOCKOUT_CYC - 1)) begin
          fail_clr = 1'b1;
          state_d  = ST_IDLE;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= ST_IDLE;
      tmr_q           <= '0;
      in_password     <= '0;
      change_password <= '0;
      rs_q            <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_d != state_q || key_taken || state_q == ST_IDLE)
        tmr_q <= '0;
      else
        tmr_q <= tmr_q + 1'b1;
      if (pw_load)
        in_password <= acc;
      if (cpw_load)
        change_password <= acc;
      if (rs_set)
        rs_q <= 1'b1;
      else if (rs_clr)
        rs_q <= 1'b0;
    end
  end

`ifdef KEYPAD_LOCKOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fail_cnt_q <= '0;
      seen_q     <= 1'b0;
    end else begin
      if (fail_clr)
        fail_cnt_q <= '0;
      else if (fail_inc && fail_cnt_q < FAIL_W'(MAX_FAIL))
        fail_cnt_q <= fail_cnt_q + 1'b1;
      seen_q <= (state_q == ST_WAIT_RESP) && state_d == ST_WAIT_RESP && (seen_q || unlock);
    end
  end

  assign busy   = state_q == ST_PRESENT || state_q == ST_WAIT_RESP || state_q == ST_LOCKED;
  assign locked = state_q == ST_LOCKED;
`else
  wire unused_fail = fail_clr | fail_inc;
  assign busy   = state_q == ST_PRESENT;
  assign locked = 1'b0;
`endif

  assign rs_button   = rs_q;
  assign e_button    = state_q == ST_PRESENT;
  assign digit_count = digit_cnt;

endmodule

// File: tb/tb_keypad_entry.sv
// Directed bench for keypad_entry; lockout scenarios run when KEYPAD_LOCKOUT_EN is defined.
module tb_keypad_entry;
  import home_pkg::*;

  localparam int unsigned RESP_WAIT = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        key_valid = 1'b0;
  logic [3:0]  key_code = 4'h0;
  logic        unlock = 1'b1;
  logic [16:0] in_password, change_password;
  logic        rs_button, e_button, busy, locked;
  logic [2:0]  digit_count;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  always #5 clk = ~clk;

  keypad_entry #(
    .MAX_DIGITS (5),
    .PW_W       (17),
    .TIMEOUT_CYC(1000),
    .E_HOLD     (4),
    .RESP_WAIT  (RESP_WAIT),
    .MAX_FAIL   (3),
    .LOCKOUT_CYC(5000)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .key_valid      (key_valid),
    .key_code       (key_code),
    .unlock         (unlock),
    .in_password    (in_password),
    .change_password(change_password),
    .rs_button      (rs_button),
    .e_button       (e_button),
    .busy           (busy),
    .locked         (locked),
    .digit_count    (digit_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic cycles(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input logic [3:0] code);
    @(negedge clk);
    key_valid = 1'b1;
    key_code  = code;
    @(negedge clk);
    key_valid = 1'b0;
    key_code  = 4'h0;
  endtask

  task automatic settle();
`ifdef KEYPAD_LOCKOUT_EN
    cycles(RESP_WAIT + 1);
`else
    cycles(1);
`endif
  endtask

`ifdef KEYPAD_LOCKOUT_EN
  // Submits 45; optional one-cycle unlock pulse inside the response window.
  task automatic submit_45(input logic pulse);
    press(4'd4);
    press(4'd5);
    press(KEY_ENTER);
    cycles(5);
    if (pulse) unlock = 1'b1;
    cycles(1);
    unlock = 1'b0;
    cycles(6);
  endtask
`endif

  initial begin
    cycles(3);
    rst = 1'b0;
    cycles(1);
    check("rst_in_pw",  32'(in_password), 0);
    check("rst_chg_pw", 32'(change_password), 0);
    check("rst_rs",     32'(rs_button), 0);
    check("rst_e",      32'(e_button), 0);
    check("rst_busy",   32'(busy), 0);
    check("rst_locked", 32'(locked), 0);
    check("rst_cnt",    32'(digit_count), 0);

    // Plain entry 45675
    press(4'd4); press(4'd5); press(4'd6); press(4'd7); press(4'd5);
    check("plain_cnt", 32'(digit_count), 5);
    press(KEY_ENTER);
    check("plain_pw", 32'(in_password), 45675);
    check("plain_rs", 32'(rs_button), 0);
    for (int i = 0; i < 4; i++) begin
      check("plain_e_hold", 32'(e_button), 1);
      check("plain_busy",   32'(busy), 1);
      cycles(1);
    end
    check("plain_e_drop", 32'(e_button), 0);
`ifdef KEYPAD_LOCKOUT_EN
    check("plain_busy_wait", 32'(busy), 1);
    cycles(RESP_WAIT);
`endif
    check("plain_busy_done", 32'(busy), 0);

    // Sixth digit dropped
    press(4'd1); press(4'd2); press(4'd3); press(4'd4); press(4'd5); press(4'd6);
    check("sat_cnt", 32'(digit_count), 5);
    press(KEY_ENTER);
    check("sat_pw", 32'(in_password), 12345);
    cycles(4);
    settle();

    // Change 45675 -> 78954
    press(KEY_CHANGE);
    press(4'd4); press(4'd5); press(4'd6); press(4'd7); press(4'd5);
    press(KEY_ENTER);
    check("chg_old_pw",  32'(in_password), 45675);
    check("chg_old_cnt", 32'(digit_count), 0);
    check("chg_old_e",   32'(e_button), 0);
    check("chg_old_rs",  32'(rs_button), 0);
    press(4'd7); press(4'd8); press(4'd9); press(4'd5); press(4'd4);
    press(KEY_ENTER);
    check("chg_new_pw", 32'(change_password), 78954);
    check("chg_keep_old", 32'(in_password), 45675);
    for (int i = 0; i < 4; i++) begin
      check("chg_e_hold",  32'(e_button), 1);
      check("chg_rs_hold", 32'(rs_button), 1);
      cycles(1);
    end
    check("chg_e_drop",  32'(e_button), 0);
    check("chg_rs_drop", 32'(rs_button), 0);
    check("chg_busy",    32'(busy), 0);

    // Keys discarded while presenting
    press(4'd4); press(4'd5); press(KEY_ENTER);
    press(4'd7);
    cycles(2);
    settle();
    check("present_discard_cnt", 32'(digit_count), 0);
    check("present_pw", 32'(in_password), 45);

    // CLEAR aborts, codes D-F ignored
    press(4'd3); press(KEY_CLEAR);
    check("clear_cnt", 32'(digit_count), 0);
    press(KEY_ENTER);
    check("clear_enter_e", 32'(e_button), 0);
    press(4'd1); press(4'hE);
    check("ignore_e_cnt", 32'(digit_count), 1);
    press(KEY_CLEAR);

    // Inter-key timeout
    press(4'd9);
    check("to_cnt_start", 32'(digit_count), 1);
    cycles(990);
    check("to_cnt_before", 32'(digit_count), 1);
    cycles(15);
    check("to_cnt_after", 32'(digit_count), 0);
    press(KEY_ENTER);
    check("to_enter_e", 32'(e_button), 0);
    cycles(2);
    check("to_enter_e_late", 32'(e_button), 0);

`ifdef KEYPAD_LOCKOUT_EN
    unlock = 1'b0;
    submit_45(1'b0);
    check("lk_fail1", 32'(locked), 0);
    submit_45(1'b0);
    check("lk_fail2", 32'(locked), 0);
    submit_45(1'b0);
    check("lk_locked", 32'(locked), 1);
    check("lk_busy",   32'(busy), 1);
    press(4'd1);
    check("lk_key_ignored", 32'(digit_count), 0);
    cycles(4980);
    check("lk_still_locked", 32'(locked), 1);
    cycles(30);
    check("lk_released", 32'(locked), 0);
    submit_45(1'b0);
    submit_45(1'b0);
    submit_45(1'b1);
    check("lk_unlock_reset", 32'(locked), 0);
    submit_45(1'b0);
    submit_45(1'b0);
    check("lk_after_reset2", 32'(locked), 0);
    submit_45(1'b0);
    check("lk_relock", 32'(locked), 1);
    unlock = 1'b1;
`endif

    // Asynchronous reset during PRESENT
    rst = 1'b1;
    cycles(1);
    rst = 1'b0;
    press(KEY_CHANGE); press(4'd1); press(KEY_ENTER); press(4'd2); press(KEY_ENTER);
    check("rp_e_pre",  32'(e_button), 1);
    check("rp_rs_pre", 32'(rs_button), 1);
    #2 rst = 1'b1;
    #1;
    check("rp_e",      32'(e_button), 0);
    check("rp_rs",     32'(rs_button), 0);
    check("rp_in_pw",  32'(in_password), 0);
    check("rp_chg_pw", 32'(change_password), 0);
    check("rp_busy",   32'(busy), 0);
    check("rp_cnt",    32'(digit_count), 0);
    check("rp_locked", 32'(locked), 0);
    cycles(2);
    rst = 1'b0;
    cycles(4);
    check("rp_e_after", 32'(e_button), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
